// File: rtl/pipe_hazard_ctrl.sv
// Unified hazard controller for the 5-stage MIPS pipeline.
// Detects load-use data hazards and in-flight control transfers.
// Drives the PC/IF-ID hold, the ID/EX bubble and the IF/ID squash.
// Also keeps saturating perf counters of stall and flush cycles.
//
// Handshake/timing: there is no valid/ready pairing here. Every output is a
// pure function of registered state plus the current inputs, so the pipeline
// observes hold/squash decisions in the same cycle the hazard is seen.
module pipe_hazard_ctrl #(
  parameter int OP_W          = 6,
  parameter int INSTR_W       = 32,
  parameter int RESOLVE_DEPTH = 3,
  parameter int MODE          = 0,
  parameter int LOAD_USE_CYC  = 1,
  parameter int CNT_W         = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid,
  input  logic [OP_W-1:0]    id_op,
  input  logic [4:0]         id_rs,
  input  logic [4:0]         id_rt,
  input  logic               ex_is_load,
  input  logic [4:0]         ex_rt,
  input  logic               br_resolved,
  input  logic               br_taken,
  input  logic [INSTR_W-1:0] if_instr_in,
  input  logic [INSTR_W-1:0] id_instr_in,
  output logic [INSTR_W-1:0] if_instr_out,
  output logic [INSTR_W-1:0] id_instr_out,
  output logic               pc_hold,
  output logic               ifid_hold,
  output logic               ctrl_pending,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  localparam logic [OP_W-1:0] OP_BEQ = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_BNE = OP_W'(6'b000101);
  localparam logic [OP_W-1:0] OP_J   = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_JAL = OP_W'(6'b000011);
  localparam logic [3:0]      PEND_INIT = 4'(RESOLVE_DEPTH);
  localparam logic [2:0]      DS_INIT   = 3'(LOAD_USE_CYC - 1);

  logic [3:0] pend_cnt;
  logic [2:0] ds_cnt;

  logic is_ctrl, lu, ds_active, flush, squash0;
  logic stall_now, ctrl_forced, flush_inc;

  // Hazard classification for the instruction currently in ID.
  always_comb begin
    is_ctrl   = id_valid & ((id_op == OP_BEQ) | (id_op == OP_BNE) |
                            (id_op == OP_J)   | (id_op == OP_JAL));
    lu        = id_valid & ex_is_load & (ex_rt != 5'd0) &
                ((ex_rt == id_rs) | (ex_rt == id_rt));
    ds_active = (ds_cnt != 3'd0);
    // A taken resolve flushes even with nothing pending: the wrong-path
    // words in IF/ID are dead regardless of our bookkeeping.
    flush     = (MODE == 1) & br_resolved & br_taken;
    squash0   = (MODE == 0) & (is_ctrl | (pend_cnt != 4'd0));
  end

  // Output selection: taken-flush > data stall > mode-0 squash > pass-through.
  always_comb begin
    if_instr_out = if_instr_in;
    id_instr_out = id_instr_in;
    pc_hold      = 1'b0;
    ifid_hold    = 1'b0;
    stall_now    = 1'b0;
    ctrl_forced  = 1'b0;
    flush_inc    = 1'b0;
    if (flush) begin
      if_instr_out = '0;
      id_instr_out = '0;
      ctrl_forced  = 1'b1;
      // A slot that already carried a NOP is not counted as flushed.
      flush_inc    = (if_instr_in != '0) | (id_instr_in != '0);
    end else if (lu | ds_active) begin
      pc_hold      = 1'b1;
      ifid_hold    = 1'b1;
      id_instr_out = '0;
      stall_now    = 1'b1;
    end else if (squash0) begin
      if_instr_out = '0;
      ctrl_forced  = 1'b1;
      flush_inc    = (if_instr_in != '0);
    end
  end

  assign ctrl_pending = (pend_cnt != 4'd0);

  // Stall/pending countdowns and saturating perf counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_cnt  <= 4'd0;
      ds_cnt    <= 3'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      // A hazard seen while a stall is already running is absorbed by it.
      if (flush)          ds_cnt <= 3'd0;
      else if (ds_active) ds_cnt <= ds_cnt - 3'd1;
      else if (lu)        ds_cnt <= DS_INIT;

      // A ctrl op only leaves ID when it is neither stalled nor flushed;
      // that departure reloads the window even over a same-cycle resolve.
      if (is_ctrl & ~stall_now & ~flush) pend_cnt <= PEND_INIT;
      else if (br_resolved)              pend_cnt <= 4'd0;
      else if (pend_cnt != 4'd0)         pend_cnt <= pend_cnt - 4'd1;

      if (pc_hold && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (ctrl_forced && flush_inc && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl.
// Three instances share one stimulus bus:
//   a: MODE 0, LOAD_USE_CYC 2, CNT_W 16
//   b: MODE 1, LOAD_USE_CYC 2, CNT_W 16
//   c: MODE 0, LOAD_USE_CYC 1, CNT_W 4
// Each scenario task checks only the instance it targets.
module tb_pipe_hazard_ctrl;

  localparam int EW = 67;  // {pc_hold, ifid_hold, ctrl_pending, if_out, id_out}
  localparam logic [5:0] OP_ADD = 6'b000000;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, ex_is_load, br_resolved, br_taken;
  logic [5:0]  id_op;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic [31:0] if_instr, id_instr;

  logic [31:0] a_if_out, a_id_out, b_if_out, b_id_out, c_if_out, c_id_out;
  logic        a_pc_hold, a_ifid_hold, a_pend;
  logic        b_pc_hold, b_ifid_hold, b_pend;
  logic        c_pc_hold, c_ifid_hold, c_pend;
  logic [15:0] a_stall_cnt, a_flush_cnt, b_stall_cnt, b_flush_cnt;
  logic [3:0]  c_stall_cnt, c_flush_cnt;

  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // Clock and reset block.
  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MODE(0), .LOAD_USE_CYC(2), .RESOLVE_DEPTH(3), .CNT_W(16)) u_a (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt),
    .ex_is_load(ex_is_load), .ex_rt(ex_rt), .br_resolved(br_resolved), .br_taken(br_taken),
    .if_instr_in(if_instr), .id_instr_in(id_instr), .if_instr_out(a_if_out), .id_instr_out(a_id_out),
    .pc_hold(a_pc_hold), .ifid_hold(a_ifid_hold), .ctrl_pending(a_pend),
    .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt));

  pipe_hazard_ctrl #(.MODE(1), .LOAD_USE_CYC(2), .RESOLVE_DEPTH(3), .CNT_W(16)) u_b (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt),
    .ex_is_load(ex_is_load), .ex_rt(ex_rt), .br_resolved(br_resolved), .br_taken(br_taken),
    .if_instr_in(if_instr), .id_instr_in(id_instr), .if_instr_out(b_if_out), .id_instr_out(b_id_out),
    .pc_hold(b_pc_hold), .ifid_hold(b_ifid_hold), .ctrl_pending(b_pend),
    .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt));

  pipe_hazard_ctrl #(.MODE(0), .LOAD_USE_CYC(1), .RESOLVE_DEPTH(3), .CNT_W(4)) u_c (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt),
    .ex_is_load(ex_is_load), .ex_rt(ex_rt), .br_resolved(br_resolved), .br_taken(br_taken),
    .if_instr_in(if_instr), .id_instr_in(id_instr), .if_instr_out(c_if_out), .id_instr_out(c_id_out),
    .pc_hold(c_pc_hold), .ifid_hold(c_ifid_hold), .ctrl_pending(c_pend),
    .stall_cnt(c_stall_cnt), .flush_cnt(c_flush_cnt));

  function automatic logic [EW-1:0] pack(input logic h, input logic f, input logic p,
                                         input logic [31:0] ifo, input logic [31:0] ido);
    return {h, f, p, ifo, ido};
  endfunction

  function automatic logic [EW-1:0] obs_a();
    return {a_pc_hold, a_ifid_hold, a_pend, a_if_out, a_id_out};
  endfunction
  function automatic logic [EW-1:0] obs_b();
    return {b_pc_hold, b_ifid_hold, b_pend, b_if_out, b_id_out};
  endfunction
  function automatic logic [EW-1:0] obs_c();
    return {c_pc_hold, c_ifid_hold, c_pend, c_if_out, c_id_out};
  endfunction

  // Driver: quiet bus with fresh nonzero instruction words.
  task automatic drive_idle();
    id_valid    = 1'b0;
    id_op       = OP_ADD;
    id_rs       = 5'd0;
    id_rt       = 5'd0;
    ex_is_load  = 1'b0;
    ex_rt       = 5'd0;
    br_resolved = 1'b0;
    br_taken    = 1'b0;
    if_instr    = {16'hA5A5, 16'($urandom_range(1, 65535))};
    id_instr    = {16'h5A5A, 16'($urandom_range(1, 65535))};
  endtask

  // Driver: two-cycle synchronous reset, released just after an edge.
  task automatic do_reset();
    @(posedge clk); #1;
    drive_idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [EW-1:0] e;
    do_reset();
    drive_idle();
    exp_q.push_back(pack(1'b0, 1'b0, 1'b0, if_instr, id_instr));
    @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs_a() !== e) begin n_err++; $display("FAIL reset_a: got %h want %h", obs_a(), e); end
    n_cmp++;
    if (obs_b() !== e) begin n_err++; $display("FAIL reset_b: got %h want %h", obs_b(), e); end
    n_cmp++;
    if ({a_stall_cnt, a_flush_cnt, c_stall_cnt, c_flush_cnt} !== 40'd0) begin
      n_err++;
      $display("FAIL reset_cnt: got %h/%h/%h/%h want 0", a_stall_cnt, a_flush_cnt, c_stall_cnt, c_flush_cnt);
    end
  endtask

  // lw $2 in EX, add rs=$2 in ID, LOAD_USE_CYC=2: two held cycles, two bubbles.
  task automatic test_load_use();
    logic [EW-1:0] e;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      drive_idle();
      id_valid = 1'b1; id_rs = 5'd2; id_rt = 5'd3;
      if (c == 0) begin ex_is_load = 1'b1; ex_rt = 5'd2; end
      exp_q.push_back(pack(c < 2, c < 2, 1'b0, if_instr, (c < 2) ? 32'd0 : id_instr));
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_a() !== e) begin n_err++; $display("FAIL load_use c%0d: got %h want %h", c, obs_a(), e); end
    end
    n_cmp++;
    if (a_stall_cnt !== 16'd2) begin n_err++; $display("FAIL load_use_stall_cnt: got %0d want 2", a_stall_cnt); end
  endtask

  // beq in ID, no resolve: fetch squashed 4 cycles, ctrl_pending 3 cycles.
  task automatic test_mode0_squash();
    logic [EW-1:0] e;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      drive_idle();
      if (c == 0) begin id_valid = 1'b1; id_op = OP_BEQ; id_rs = 5'd4; id_rt = 5'd5; end
      exp_q.push_back(pack(1'b0, 1'b0, (c >= 1 && c <= 3), (c <= 3) ? 32'd0 : if_instr, id_instr));
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_a() !== e) begin n_err++; $display("FAIL mode0_squash c%0d: got %h want %h", c, obs_a(), e); end
    end
    n_cmp++;
    if (a_flush_cnt !== 16'd4) begin n_err++; $display("FAIL mode0_flush_cnt: got %0d want 4", a_flush_cnt); end
  endtask

  // beq then br_resolved one cycle later: pending drops on the next cycle.
  task automatic test_early_resolve();
    logic [EW-1:0] e;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      drive_idle();
      if (c == 0) begin id_valid = 1'b1; id_op = OP_BEQ; end
      if (c == 1) begin br_resolved = 1'b1; br_taken = 1'b1; end
      exp_q.push_back(pack(1'b0, 1'b0, c == 1, (c <= 1) ? 32'd0 : if_instr, id_instr));
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_a() !== e) begin n_err++; $display("FAIL early_resolve c%0d: got %h want %h", c, obs_a(), e); end
    end
  endtask

  // MODE 1: bne issued unsquashed, taken resolve flushes both words once.
  task automatic test_mode1_flush();
    logic [EW-1:0] e;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      drive_idle();
      id_valid = 1'b1;
      if (c == 0) id_op = OP_BNE;
      if (c == 1) begin br_resolved = 1'b1; br_taken = 1'b1; end
      exp_q.push_back(pack(1'b0, 1'b0, c == 1, (c == 1) ? 32'd0 : if_instr, (c == 1) ? 32'd0 : id_instr));
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_b() !== e) begin n_err++; $display("FAIL mode1_flush c%0d: got %h want %h", c, obs_b(), e); end
    end
    n_cmp++;
    if (b_flush_cnt !== 16'd1) begin n_err++; $display("FAIL mode1_flush_cnt: got %0d want 1", b_flush_cnt); end
  endtask

  // Load-use and taken flush in the same cycle: flush wins, no hold.
  task automatic test_lu_flush();
    logic [EW-1:0] e;
    do_reset();
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      drive_idle();
      if (c == 0) begin
        id_valid = 1'b1; id_rs = 5'd7; ex_is_load = 1'b1; ex_rt = 5'd7;
        br_resolved = 1'b1; br_taken = 1'b1;
      end
      exp_q.push_back(pack(1'b0, 1'b0, 1'b0, (c == 0) ? 32'd0 : if_instr, (c == 0) ? 32'd0 : id_instr));
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_b() !== e) begin n_err++; $display("FAIL lu_flush c%0d: got %h want %h", c, obs_b(), e); end
    end
    n_cmp++;
    if ({b_stall_cnt, b_flush_cnt} !== {16'd0, 16'd1}) begin
      n_err++; $display("FAIL lu_flush_cnt: got %0d/%0d want 0/1", b_stall_cnt, b_flush_cnt);
    end
  endtask

  // Stalled beq: stall beats squash, pending loads only once beq leaves ID.
  task automatic test_back_to_back();
    logic [EW-1:0] e;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      drive_idle();
      if (c <= 2) begin id_valid = 1'b1; id_op = OP_BEQ; id_rs = 5'd2; id_rt = 5'd5; end
      if (c == 0) begin ex_is_load = 1'b1; ex_rt = 5'd2; end
      exp_q.push_back(pack(c <= 1, c <= 1, c == 3, (c >= 2) ? 32'd0 : if_instr, (c <= 1) ? 32'd0 : id_instr));
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_a() !== e) begin n_err++; $display("FAIL back_to_back c%0d: got %h want %h", c, obs_a(), e); end
    end
    n_cmp++;
    if ({a_stall_cnt, a_flush_cnt} !== {16'd2, 16'd1}) begin
      n_err++; $display("FAIL back_to_back_cnt: got %0d/%0d want 2/1", a_stall_cnt, a_flush_cnt);
    end
  endtask

  // CNT_W=4: 20 consecutive stall cycles saturate stall_cnt at 15.
  task automatic test_saturate();
    logic [EW-1:0] e;
    logic [3:0]    want;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      drive_idle();
      id_valid = 1'b1; id_rt = 5'd9; ex_is_load = 1'b1; ex_rt = 5'd9;
      exp_q.push_back(pack(1'b1, 1'b1, 1'b0, if_instr, 32'd0));
      @(negedge clk);
      e = exp_q.pop_front();
      want = 4'((c > 15) ? 15 : c);
      n_cmp++;
      if (obs_c() !== e || c_stall_cnt !== want) begin
        n_err++; $display("FAIL saturate c%0d: got %h cnt %0d want %h cnt %0d", c, obs_c(), c_stall_cnt, e, want);
      end
    end
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    n_cmp++;
    if (c_stall_cnt !== 4'd15 || c_pc_hold !== 1'b0) begin
      n_err++; $display("FAIL saturate_end: got cnt %0d hold %b want 15 0", c_stall_cnt, c_pc_hold);
    end
  endtask

  // Reset while a ctrl op is pending: cleared and pass-through next cycle.
  task automatic test_reset_mid_pending();
    logic [EW-1:0] e;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      drive_idle();
      reset = (c == 1);
      if (c == 0) begin id_valid = 1'b1; id_op = OP_BEQ; end
      exp_q.push_back(pack(1'b0, 1'b0, c == 1, (c <= 1) ? 32'd0 : if_instr, id_instr));
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_a() !== e) begin n_err++; $display("FAIL reset_mid_pending c%0d: got %h want %h", c, obs_a(), e); end
    end
    n_cmp++;
    if (a_flush_cnt !== 16'd0) begin n_err++; $display("FAIL reset_mid_pending_cnt: got %0d want 0", a_flush_cnt); end
  endtask

  initial begin
    reset = 1'b1;
    drive_idle();
    test_reset();
    test_load_use();
    test_mode0_squash();
    test_early_resolve();
    test_mode1_flush();
    test_lu_flush();
    test_back_to_back();
    test_saturate();
    test_reset_mid_pending();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
